// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one memory slave between two masters.
//
// Optional feature: define MEM_BUS_ARBITER_TIMEOUT_EN to enable the slave-response
// timeout (TIMEOUT_CYCLES busy cycles without s_mem_ready completes the transfer
// with rdata 32'hFFFF_FFFF and sets the sticky timeout_err flag).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_mem_* / m1_mem_*       master 0 (CPU) and master 1 (DMA) request/response
//   s_mem_*                   shared slave request/response
//   timeout_err               sticky slave-timeout flag (0 when timeout disabled)
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_mem_valid,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic        timeout_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [1:0]  state;
    logic        grant;
    logic        last;
    logic        busy;
    logic        tmo;
    logic        done;
    logic [31:0] rsp;

    // Outputs are forced low while rst is held, even before the reset edge lands.
    assign busy = (state == BUSY) && !rst;
    assign done = busy && (s_mem_ready || tmo);
    assign rsp  = tmo ? 32'hFFFF_FFFF : s_mem_rdata;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    logic [15:0] cnt;
    logic        err;
    // Fires on the TIMEOUT_CYCLES-th busy cycle; a real ready in that cycle wins.
    assign tmo         = busy && !s_mem_ready && (cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == IDLE)
                cnt <= '0;
            else if (state == BUSY && !s_mem_ready)
                cnt <= cnt + 16'd1;
            if (tmo)
                err <= 1'b1;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (m0_mem_valid || m1_mem_valid) begin
                    grant <= (m0_mem_valid && m1_mem_valid) ? !last : m1_mem_valid;
                    state <= BUSY;
                end
                BUSY: if (s_mem_ready || tmo) begin
                    last  <= grant;
                    state <= RELEASE;
                end
                RELEASE: if (!s_mem_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign s_mem_valid  = busy;
    assign s_mem_addr   = busy ? (grant ? m1_mem_addr  : m0_mem_addr)  : 32'd0;
    assign s_mem_wdata  = busy ? (grant ? m1_mem_wdata : m0_mem_wdata) : 32'd0;
    assign s_mem_wstrb  = busy ? (grant ? m1_mem_wstrb : m0_mem_wstrb) : 4'd0;
    assign m0_mem_ready = done && !grant;
    assign m1_mem_ready = done && grant;
    assign m0_mem_rdata = (!rst && !grant) ? rsp : 32'd0;
    assign m1_mem_rdata = (!rst && grant)  ? rsp : 32'd0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_mem_valid, m1_mem_valid;
    logic [31:0] m0_mem_addr, m1_mem_addr, m0_mem_wdata, m1_mem_wdata;
    logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
    logic        m0_mem_ready, m1_mem_ready;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic        s_mem_valid;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_mem_ready;
    logic [31:0] s_mem_rdata;
    logic        timeout_err;
    int          checks = 0;
    int          errors = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_mem_valid(m0_mem_valid), .m0_mem_addr(m0_mem_addr), .m0_mem_wdata(m0_mem_wdata),
        .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_addr(m1_mem_addr), .m1_mem_wdata(m1_mem_wdata),
        .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata),
        .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_mem_valid = 1'b0; m0_mem_addr = '0; m0_mem_wdata = '0; m0_mem_wstrb = '0;
        m1_mem_valid = 1'b0; m1_mem_addr = '0; m1_mem_wdata = '0; m1_mem_wstrb = '0;
        s_mem_ready = 1'b0; s_mem_rdata = '0;
        tick(); tick();
        chk("rst_svalid", 32'(s_mem_valid), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // single read from m0, slave ready one cycle after valid
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h2000_4000;
        #1 chk("t1_idle_svalid", 32'(s_mem_valid), 32'd0);
        tick();
        chk("t1_busy_svalid", 32'(s_mem_valid), 32'd1);
        chk("t1_addr", s_mem_addr, 32'h2000_4000);
        chk("t1_wait_m0rdy", 32'(m0_mem_ready), 32'd0);
        tick();
        chk("t1_busy2_svalid", 32'(s_mem_valid), 32'd1);
        s_mem_ready = 1'b1; s_mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("t1_m0rdy", 32'(m0_mem_ready), 32'd1);
        chk("t1_m0rdata", m0_mem_rdata, 32'hCAFE_F00D);
        chk("t1_m1rdy", 32'(m1_mem_ready), 32'd0);
        tick();
        m0_mem_valid = 1'b0;
        chk("t1_rel_svalid", 32'(s_mem_valid), 32'd0);
        chk("t1_rel_m0rdy", 32'(m0_mem_ready), 32'd0);
        s_mem_ready = 1'b0;
        tick();
        chk("t1_idle_addr", s_mem_addr, 32'd0);

        // tie after reset: m0 first; then tie again with m1 pending -> m1, then m0
        rst = 1'b1; tick(); rst = 1'b0;
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_1000;
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h0000_2000;
        tick();
        chk("t2_g0_addr", s_mem_addr, 32'h0000_1000);
        s_mem_ready = 1'b1; #1;
        chk("t2_g0_m0rdy", 32'(m0_mem_ready), 32'd1);
        chk("t2_g0_m1rdy", 32'(m1_mem_ready), 32'd0);
        tick();
        m0_mem_addr = 32'h0000_1004;
        s_mem_ready = 1'b0;
        tick(); tick();
        chk("t2_g1_addr", s_mem_addr, 32'h0000_2000);
        s_mem_ready = 1'b1; #1;
        chk("t2_g1_m1rdy", 32'(m1_mem_ready), 32'd1);
        chk("t2_g1_m0rdy", 32'(m0_mem_ready), 32'd0);
        tick();
        m1_mem_valid = 1'b0;
        s_mem_ready = 1'b0;
        tick(); tick();
        chk("t2_g2_addr", s_mem_addr, 32'h0000_1004);
        s_mem_ready = 1'b1; #1;
        chk("t2_g2_m0rdy", 32'(m0_mem_ready), 32'd1);
        tick();
        m0_mem_valid = 1'b0;
        s_mem_ready = 1'b0;
        tick();

        // m1 write; slave holds ready through RELEASE while m0 waits
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h2000_5120;
        m1_mem_wdata = 32'd42042; m1_mem_wstrb = 4'b1111;
        tick();
        chk("t3_addr", s_mem_addr, 32'h2000_5120);
        chk("t3_wdata", s_mem_wdata, 32'd42042);
        chk("t3_wstrb", 32'(s_mem_wstrb), 32'hF);
        s_mem_ready = 1'b1; #1;
        chk("t3_m1rdy", 32'(m1_mem_ready), 32'd1);
        tick();
        m1_mem_valid = 1'b0;
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_3000; m0_mem_wstrb = 4'b0000;
        chk("t3_rel1_svalid", 32'(s_mem_valid), 32'd0);
        chk("t3_rel1_m1rdy", 32'(m1_mem_ready), 32'd0);
        tick();
        chk("t3_rel2_svalid", 32'(s_mem_valid), 32'd0);
        tick();
        chk("t3_rel3_svalid", 32'(s_mem_valid), 32'd0);
        s_mem_ready = 1'b0;
        tick();
        chk("t3_idle_svalid", 32'(s_mem_valid), 32'd0);
        tick();
        chk("t3_m0_addr", s_mem_addr, 32'h0000_3000);
        chk("t3_m0_wstrb", 32'(s_mem_wstrb), 32'd0);
        m0_mem_valid = 1'b0; #1;
        chk("t4_drop_svalid", 32'(s_mem_valid), 32'd1);
        tick();
        chk("t4_drop_svalid2", 32'(s_mem_valid), 32'd1);
        s_mem_ready = 1'b1; #1;
        chk("t4_m0rdy", 32'(m0_mem_ready), 32'd1);
        tick();
        s_mem_ready = 1'b0;
        tick();

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_4000;
        tick();
        chk("to_c1_m0rdy", 32'(m0_mem_ready), 32'd0);
        tick(); tick();
        chk("to_c3_m0rdy", 32'(m0_mem_ready), 32'd0);
        tick();
        chk("to_c4_m0rdy", 32'(m0_mem_ready), 32'd1);
        chk("to_c4_rdata", m0_mem_rdata, 32'hFFFF_FFFF);
        tick();
        m0_mem_valid = 1'b0;
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_rel_m0rdy", 32'(m0_mem_ready), 32'd0);
        tick(); tick();
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
`endif

        // reset mid-BUSY abandons the transaction
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_5000;
        tick();
        chk("t5_busy_svalid", 32'(s_mem_valid), 32'd1);
        rst = 1'b1; s_mem_ready = 1'b1; #1;
        chk("t5_inrst_svalid", 32'(s_mem_valid), 32'd0);
        chk("t5_inrst_m0rdy", 32'(m0_mem_ready), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("t5_post_svalid", 32'(s_mem_valid), 32'd0);
        chk("t5_post_m0rdy", 32'(m0_mem_ready), 32'd0);
        chk("t5_post_m1rdy", 32'(m1_mem_ready), 32'd0);
        chk("t5_post_err", 32'(timeout_err), 32'd0);
        m0_mem_valid = 1'b0; s_mem_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
